// File: rtl/micro_sequencer.sv
// micro_sequencer: control-store address register with next-address logic.
// Computes the next microaddress from a 3-bit branch code. The code selects
// increment, two table dispatches, jump, conditional branch, call/return
// through a small LIFO return stack, or restart. Stack overflow and
// underflow are latched in sticky error flags.
module micro_sequencer #(
    parameter int unsigned                   STATE_W     = 4,
    parameter int unsigned                   IN_W        = 2,
    parameter int unsigned                   STACK_DEPTH = 4,
    parameter logic [STATE_W-1:0]            RESET_STATE = '0,
    parameter logic [(2**IN_W)*STATE_W-1:0]  DISP1_TABLE = 16'h6654,
    parameter logic [(2**IN_W)*STATE_W-1:0]  DISP2_TABLE = 16'hCCCB
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic [2:0]                           branch_control,
    input  logic [IN_W-1:0]                      in,
    input  logic                                 cond,
    input  logic [STATE_W-1:0]                   br_addr,
    input  logic                                 clr_err,
    output logic [STATE_W-1:0]                   current_state,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_level,
    output logic                                 stack_overflow,
    output logic                                 stack_underflow
);

    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_INC     = 3'd0,
        OP_DISP1   = 3'd1,
        OP_DISP2   = 3'd2,
        OP_JMP     = 3'd3,
        OP_CALL    = 3'd4,
        OP_RET     = 3'd5,
        OP_BRC     = 3'd6,
        OP_RESTART = 3'd7
    } op_e;

    op_e                op;
    logic [STATE_W-1:0] disp1 [2**IN_W];
    logic [STATE_W-1:0] disp2 [2**IN_W];
    logic [STATE_W-1:0] stack [STACK_DEPTH];
    logic [STATE_W-1:0] inc_state;
    logic [STATE_W-1:0] top;
    logic [STATE_W-1:0] next_state;
    logic [LVL_W-1:0]   next_level;
    logic               push;
    logic               ovf_evt;
    logic               unf_evt;

    assign op = op_e'(branch_control);

    // Unpack the flat dispatch tables so the index input selects an entry directly
    for (genvar k = 0; k < 2**IN_W; k++) begin : g_tab
        assign disp1[k] = DISP1_TABLE[k*STATE_W +: STATE_W];
        assign disp2[k] = DISP2_TABLE[k*STATE_W +: STATE_W];
    end

    // Top-of-stack read: entry just below the current fill level
    always_comb begin
        top = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (stack_level == LVL_W'(i + 1)) top = stack[i];
        end
    end

    // Next-address and stack-control decode; en=0 leaves everything unchanged
    always_comb begin
        inc_state  = current_state + 1'b1;
        next_state = current_state;
        next_level = stack_level;
        push       = 1'b0;
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        if (en) begin
            case (op)
                OP_INC:   next_state = inc_state;
                OP_DISP1: next_state = disp1[in];
                OP_DISP2: next_state = disp2[in];
                OP_JMP:   next_state = br_addr;
                OP_CALL: begin
                    next_state = br_addr;
                    if (stack_level < FULL_LEVEL) begin
                        push       = 1'b1;
                        next_level = stack_level + 1'b1;
                    end else begin
                        ovf_evt = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stack_level != '0) begin
                        next_state = top;
                        next_level = stack_level - 1'b1;
                    end else begin
                        next_state = RESET_STATE;
                        unf_evt    = 1'b1;
                    end
                end
                OP_BRC:     next_state = cond ? br_addr : inc_state;
                OP_RESTART: begin
                    next_state = RESET_STATE;
                    next_level = '0;
                end
            endcase
        end
    end

    // Return-stack storage; contents are don't-care after reset so no reset here
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (push && stack_level == LVL_W'(i)) stack[i] <= inc_state;
        end
    end

    // Address register, fill level and sticky flags; a new error beats clr_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_state   <= RESET_STATE;
            stack_level     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            current_state   <= next_state;
            stack_level     <= next_level;
            stack_overflow  <= ovf_evt | (stack_overflow  & ~clr_err);
            stack_underflow <= unf_evt | (stack_underflow & ~clr_err);
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer with default parameters.
// Directed scenarios followed by randomized opcodes, all checked against a
// queue-based reference model of the sequencing rules.
module tb_micro_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] branch_control;
    logic [1:0] in;
    logic       cond;
    logic [3:0] br_addr;
    logic       clr_err;
    logic [3:0] current_state;
    logic [2:0] stack_level;
    logic       stack_overflow;
    logic       stack_underflow;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int m_state;
    int m_q[$];
    int m_ovf;
    int m_unf;
    int disp1_map[4] = '{4, 5, 6, 6};
    int disp2_map[4] = '{11, 12, 12, 12};

    micro_sequencer #(
        .STATE_W(4), .IN_W(2), .STACK_DEPTH(4), .RESET_STATE(4'd0),
        .DISP1_TABLE(16'h6654), .DISP2_TABLE(16'hCCCB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .branch_control(branch_control),
        .in(in), .cond(cond), .br_addr(br_addr), .clr_err(clr_err),
        .current_state(current_state), .stack_level(stack_level),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/state"}, 32'(current_state),   32'(m_state));
        check({tag, "/level"}, 32'(stack_level),     32'(m_q.size()));
        check({tag, "/ovf"},   32'(stack_overflow),  32'(m_ovf));
        check({tag, "/unf"},   32'(stack_underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        m_state = 0;
        m_q.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_step(input bit e, input int op, input int ix, input bit c,
                              input int br, input bit clr);
        int nxt;
        int s1;
        bit new_ovf;
        bit new_unf;
        s1 = (m_state + 1) % 16;
        nxt = m_state;
        new_ovf = 0;
        new_unf = 0;
        if (e) begin
            case (op)
                0: nxt = s1;
                1: nxt = disp1_map[ix];
                2: nxt = disp2_map[ix];
                3: nxt = br;
                4: begin
                    nxt = br;
                    if (m_q.size() < DEPTH) m_q.push_back(s1);
                    else new_ovf = 1;
                end
                5: begin
                    if (m_q.size() > 0) nxt = m_q.pop_back();
                    else begin nxt = 0; new_unf = 1; end
                end
                6: nxt = c ? br : s1;
                default: begin nxt = 0; m_q.delete(); end
            endcase
        end
        m_state = nxt;
        m_ovf = new_ovf ? 1 : (clr ? 0 : m_ovf);
        m_unf = new_unf ? 1 : (clr ? 0 : m_unf);
    endtask

    // Drive one cycle's inputs, advance one edge, compare against the model
    task automatic do_step(input bit e, input int op, input int ix, input bit c,
                           input int br, input bit clr, input string tag);
        en = e;
        branch_control = 3'(op);
        in = 2'(ix);
        cond = c;
        br_addr = 4'(br);
        clr_err = clr;
        model_step(e, op, ix, c, br, clr);
        @(posedge clk);
        #1;
        en = 1'b0;
        clr_err = 1'b0;
        check_all(tag);
    endtask

    // Synchronous-looking reset pulse placed away from the active edge
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        branch_control = '0;
        in = '0;
        cond = 1'b0;
        br_addr = '0;
        clr_err = 1'b0;

        // Power-on reset and counting with wrap
        do_reset();
        for (int i = 0; i < 17; i++) do_step(1, 0, 0, 0, 0, 0, "inc");

        // Dispatch tables from state 3
        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int i = 0; i < 3; i++) do_step(1, 0, 0, 0, 0, 0, "inc_to3");
            do_step(1, 1, k, 0, 0, 0, "disp1");
        end
        for (int k = 0; k < 4; k += 2) begin
            do_reset();
            for (int i = 0; i < 3; i++) do_step(1, 0, 0, 0, 0, 0, "inc_to3");
            do_step(1, 2, k, 0, 0, 0, "disp2");
        end

        // Call / return pair
        do_reset();
        do_step(1, 0, 0, 0, 0, 0, "inc");
        do_step(1, 0, 0, 0, 0, 0, "inc");
        do_step(1, 4, 0, 0, 9, 0, "call9");
        do_step(1, 0, 0, 0, 0, 0, "inc_sub");
        do_step(1, 5, 0, 0, 0, 0, "ret");

        // Overflow, drain, underflow, clear
        do_reset();
        for (int i = 0; i < 5; i++) do_step(1, 4, 0, 0, 8, 0, "call_ovf");
        for (int i = 0; i < 5; i++) do_step(1, 5, 0, 0, 0, 0, "ret_unf");
        do_step(0, 0, 0, 0, 0, 1, "clr_err");

        // Conditional branch and hold
        do_step(1, 3, 0, 0, 5, 0, "jmp5");
        do_step(1, 6, 0, 1, 14, 0, "brc_taken");
        do_step(1, 6, 0, 0, 14, 0, "brc_not");
        for (int i = 0; i < 3; i++)
            do_step(0, int'($urandom_range(0, 7)), 0, 1, 3, 0, "hold");

        // Same-edge clear and new error: the error wins
        do_step(1, 5, 0, 0, 0, 1, "unf_vs_clr");

        // Asynchronous reset in the middle of a cycle
        do_reset();
        for (int i = 0; i < 5; i++) do_step(1, 4, 0, 0, 8, 0, "call_fill");
        do_step(1, 5, 0, 0, 0, 0, "ret_a");
        do_step(1, 5, 0, 0, 0, 0, "ret_b");
        do_step(1, 3, 0, 0, 7, 0, "jmp7");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        #2;
        rst_n = 1'b1;
        do_step(1, 0, 0, 0, 0, 0, "post_reset_inc");

        // Randomized opcode stream
        for (int i = 0; i < 600; i++) begin
            bit e;
            bit c;
            bit clr;
            int op;
            e   = ($urandom_range(0, 99) < 85);
            op  = int'($urandom_range(0, 7));
            if (op == 7 && $urandom_range(0, 3) != 0) op = 4;
            c   = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 9) == 0);
            do_step(e, op, int'($urandom_range(0, 3)), c,
                    int'($urandom_range(0, 15)), clr, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
